debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Parametrised multi-channel debouncer; successor to the single-channel 4-sample debouncer.
//  Per channel: 2-flop synchroniser, then a run-length counter.
//  The debounced level flips only after STABLE consecutive sample ticks disagree with it.
//  Registered rise/fall pulses drive the frequency-counter front end; an optional shared prescaler slows sampling.
// PARAMETERS
//  CHANNELS   4   number of independent input lines (>=1)
//  STABLE     4   consecutive disagreeing ticks required to flip state (>=1)
//  PRESCALE   1   clocks per sample tick (>=1; 1 = sample every clock)
//  INIT_LEVEL 0   level loaded into synchronisers and oState on reset (0 or 1, all channels)
// PORTS
//  iClk     in   1         system clock, all logic on rising edge
//  iReset   in   1         synchronous, active-high reset
//  iIn      in   CHANNELS  raw asynchronous (bouncy) inputs
//  oState   out  CHANNELS  debounced level per channel
//  oRise    out  CHANNELS  1-clock pulse when oState[i] goes 0->1
//  oFall    out  CHANNELS  1-clock pulse when oState[i] goes 1->0
//  oTick    out  1         1-clock pulse marking each sample tick (debug/test)
// BEHAVIOUR
//  Reset (iReset=1 at an edge) loads: sync stages = INIT_LEVEL, oState = INIT_LEVEL.
//  Reset also clears: all run counters = 0, prescaler = 0, oRise = oFall = 0, oTick = 0.
//  Reset mid-operation discards all partial counts; no rise/fall pulse is produced by reset itself.
//  Prescaler: counter 0..PRESCALE-1, wraps to 0. tick = (presc == PRESCALE-1).
//   For PRESCALE=1, tick = 1 every cycle. oTick is tick registered; with PRESCALE=1 it is 1 every cycle from the first post-reset edge.
//  Synchroniser: s1 <= iIn; s2 <= s1 every clock, independent of tick. Only s2 feeds the logic.
//  Per channel i, evaluated at each rising edge where tick=1:
//   s2[i] == oState[i]                      -> cnt[i] <= 0
//   s2[i] != oState[i], cnt[i] <  STABLE-1  -> cnt[i] <= cnt[i]+1
//   s2[i] != oState[i], cnt[i] == STABLE-1  -> oState[i] <= s2[i]; cnt[i] <= 0; pulse
//  Pulse: oRise[i] (new level 1) or oFall[i] (new level 0) is high for exactly the one clock following the flip edge.
//  oRise[i] and oFall[i] are never both high; any number of channels may pulse in the same cycle.
//  Edges with tick=0: cnt and oState hold; oRise/oFall deassert.
//  Any single tick where s2 agrees with oState restarts the run. Glitches shorter than STABLE ticks never reach oState.
//  Counter width = $clog2(STABLE+1); the counter never exceeds STABLE-1, so no wrap.
//  Prescaler width = $clog2(PRESCALE+1).
//  Latency, PRESCALE=1: a clean input step applied before edge k appears on oState at edge k+STABLE+1
//   (2 sync edges + STABLE ticks). For PRESCALE>1, add up to PRESCALE-1 clocks per tick alignment.
//  STABLE=1: flip on the first tick that disagrees.
//  Channels are fully independent; only the prescaler is shared.
// TESTING
//  T1 reset: INIT_LEVEL=0, hold iIn=4'hF, assert iReset 3 clk -> oState=0, oRise=oFall=0 throughout reset.
//  T2 clean step, STABLE=4, PRESCALE=1: iIn[0] 0->1 before edge k
//     -> oState[0]=1 after edge k+5; oRise[0]=1 for exactly that one cycle only.
//  T3 bounce: iIn[1] toggles 1,0,1,0 every 2 clk, then holds 1 -> no oState[1] change during the bounce.
//     oState[1] rises STABLE+2 edges after the final transition; exactly one oRise.
//  T4 glitch: iIn[2] high for 3 clk (STABLE=4) then low -> oState[2] stays 0, no pulses.
//     A 4-clk pulse produces oRise then, 6 edges after its fall, oFall.
//  T5 prescaler, PRESCALE=3, STABLE=2: oTick every 3rd clk; step on iIn[3] -> flip after 2 ticks, within 2+6 clk.
//  T6 simultaneous + reset: step all channels together -> all oRise in the same cycle.
//     Assert iReset at cnt=STABLE-2 on a pending step -> counts cleared; a full STABLE run is needed after release.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: two-flop synchroniser per line, then a run-length
// counter that flips the debounced level after STABLE consecutive disagreeing sample ticks.
module debounce_multi #(
    parameter int CHANNELS   = 4,
    parameter int STABLE     = 4,
    parameter int PRESCALE   = 1,
    parameter int INIT_LEVEL = 0
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic [CHANNELS-1:0] iIn,
    output logic [CHANNELS-1:0] oState,
    output logic [CHANNELS-1:0] oRise,
    output logic [CHANNELS-1:0] oFall,
    output logic                oTick
);

    localparam int CW = $clog2(STABLE + 1);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic          INIT_BIT   = (INIT_LEVEL != 0);

    logic [CHANNELS-1:0] sync_1;
    logic [CHANNELS-1:0] sync_2;
    logic [CW-1:0]       run_cnt [CHANNELS];
    logic [PW-1:0]       presc;
    logic                tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            sync_1 <= {CHANNELS{INIT_BIT}};
            sync_2 <= {CHANNELS{INIT_BIT}};
            oState <= {CHANNELS{INIT_BIT}};
            oRise  <= '0;
            oFall  <= '0;
            oTick  <= 1'b0;
            presc  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                run_cnt[i] <= '0;
            end
        end else begin
            sync_1 <= iIn;
            sync_2 <= sync_1;
            oTick  <= tick;
            presc  <= tick ? '0 : presc + PW'(1);
            // Pulses default low so they last exactly one clock after a flip.
            oRise  <= '0;
            oFall  <= '0;
            if (tick) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (sync_2[i] == oState[i]) begin
                        run_cnt[i] <= '0;
                    end else if (run_cnt[i] == CNT_LAST) begin
                        run_cnt[i] <= '0;
                        oState[i]  <= sync_2[i];
                        oRise[i]   <= sync_2[i];
                        oFall[i]   <= ~sync_2[i];
                    end else begin
                        run_cnt[i] <= run_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: default instance (STABLE=4, PRESCALE=1)
// plus a prescaled instance (STABLE=2, PRESCALE=3) sharing clock and reset.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic [3:0] st_a, rise_a, fall_a;
    logic [3:0] st_b, rise_b, fall_b;
    logic       tick_a, tick_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(4), .STABLE(4), .PRESCALE(1), .INIT_LEVEL(0)) dut_a (
        .iClk(clk), .iReset(rst), .iIn(in_a),
        .oState(st_a), .oRise(rise_a), .oFall(fall_a), .oTick(tick_a)
    );

    debounce_multi #(.CHANNELS(4), .STABLE(2), .PRESCALE(3), .INIT_LEVEL(0)) dut_b (
        .iClk(clk), .iReset(rst), .iIn(in_b),
        .oState(st_b), .oRise(rise_b), .oFall(fall_b), .oTick(tick_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with inputs held high: nothing may leak out
        in_a = 4'hF;
        rst  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("t1_state", st_a, 4'h0);
            check("t1_rise", rise_a, 4'h0);
            check("t1_fall", fall_a, 4'h0);
            check("t1_tick", tick_a, 1'b0);
        end
        in_a = 4'h0;
        step();
        step();
        rst = 1'b0;
        step();
        check("t1_tick_post", tick_a, 1'b1);
        check("t1_state_post", st_a, 4'h0);

        // clean step on channel 0: flip at edge k+5
        in_a[0] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            step();
            check("t2_state", st_a[0], (j >= 5));
            check("t2_rise", rise_a[0], (j == 5));
        end

        // bounce on channel 1, then settle high
        for (int p = 0; p < 4; p++) begin
            in_a[1] = (p % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                step();
                check("t3_bounce_state", st_a[1], 1'b0);
                check("t3_bounce_rise", rise_a[1], 1'b0);
            end
        end
        in_a[1] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            check("t3_state", st_a[1], (j >= 5));
            check("t3_rise", rise_a[1], (j == 5));
        end

        // 3-clock glitch on channel 2 is filtered
        in_a[2] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("t4_glitch_state", st_a[2], 1'b0);
        end
        in_a[2] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            check("t4_glitch_state", st_a[2], 1'b0);
            check("t4_glitch_pulse", {rise_a[2], fall_a[2]}, 2'b00);
        end

        // 4-clock pulse: rise at k+5, fall at k+9
        in_a[2] = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            if (j == 3) in_a[2] = 1'b0;
            check("t4_state", st_a[2], (j >= 5 && j < 9));
            check("t4_rise", rise_a[2], (j == 5));
            check("t4_fall", fall_a[2], (j == 9));
        end

        // bring everything low, then step all channels together
        in_a = 4'h0;
        for (int j = 0; j < 8; j++) step();
        check("t6_all_low", st_a, 4'h0);
        in_a = 4'hF;
        for (int j = 0; j < 7; j++) begin
            step();
            check("t6_all_state", st_a, (j >= 5) ? 4'hF : 4'h0);
            check("t6_all_rise", rise_a, (j == 5) ? 4'hF : 4'h0);
        end
        in_a = 4'h0;
        for (int j = 0; j < 7; j++) begin
            step();
            check("t6_all_state_dn", st_a, (j >= 5) ? 4'h0 : 4'hF);
            check("t6_all_fall", fall_a, (j == 5) ? 4'hF : 4'h0);
        end

        // reset one edge after the counters reach STABLE-2: full run needed afterwards
        in_a = 4'hF;
        for (int j = 0; j < 13; j++) begin
            step();
            if (j == 3) rst = 1'b1;
            if (j == 4) rst = 1'b0;
            check("t6_rst_state", st_a, (j >= 10) ? 4'hF : 4'h0);
            check("t6_rst_rise", rise_a, (j == 10) ? 4'hF : 4'h0);
            check("t6_rst_fall", fall_a, 4'h0);
        end

        // prescaled instance: tick every third clock, flip after two ticks
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            check("t5_tick", tick_b, (j % 3 == 0));
            check("t5_idle_state", st_b, 4'h0);
        end
        in_b[3] = 1'b1;
        for (int j = 10; j <= 17; j++) begin
            step();
            check("t5_tick", tick_b, (j % 3 == 0));
            check("t5_state", st_b[3], (j >= 15));
            check("t5_rise", rise_b[3], (j == 15));
            check("t5_fall", fall_b[3], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
